ram_coef_unpacker: RTL and testbench

Read-side streamer for the 96x256 coefficient RAM. Each 96-bit RAM word holds eight 12-bit polynomial coefficients. On `start`, the block walks a run of consecutive RAM words and emits their coefficients one per cycle on a valid/ready stream toward the downstream arithmetic stages. It drives the RAM read address, samples the RAM's combinational read data, and reports `busy`/`done`.

---
 rtl/kyber_pkg.sv | 17 +
 rtl/ram_coef_unpacker.sv | 106 ++++++++++
 tb/tb_ram_coef_unpacker.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/kyber_pkg.sv
// Shared constants and state type for the coefficient RAM unpacker and its
// write-side packer counterpart.
package kyber_pkg;

   localparam int COEF_W = 12;
   localparam int LANES  = 8;
   localparam int WORD_W = COEF_W * LANES;
   localparam int ADDR_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_STREAM = 2'd2,
      ST_FIN    = 2'd3
   } unpack_state_e;

endpackage

// File: rtl/ram_coef_unpacker.sv
// Streams the 12-bit coefficients of a run of consecutive coefficient-RAM words,
// one per cycle, on a valid/ready interface.
module ram_coef_unpacker #(
   parameter int COEF_W = kyber_pkg::COEF_W,
   parameter int LANES  = kyber_pkg::LANES,
   parameter int WORD_W = kyber_pkg::WORD_W,
   parameter int ADDR_W = kyber_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   num_words,
   output logic [ADDR_W-1:0] ram_raddr,
   input  logic [WORD_W-1:0] ram_dout,
   output logic              coef_valid,
   input  logic              coef_ready,
   output logic [COEF_W-1:0] coef_data,
   output logic              coef_last,
   output logic              busy,
   output logic              done,
   output logic [1:0]        dbg_state
);
   import kyber_pkg::*;

   // Handshake: a coefficient moves when coef_valid & coef_ready at a rising
   // edge; once raised, coef_valid and the presented data hold until accepted.

   localparam int LANE_W = $clog2(LANES);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
   localparam logic [ADDR_W:0]   MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

   unpack_state_e     state_q, state_d;
   logic [WORD_W-1:0] shift_q, shift_d;
   logic [LANE_W-1:0] lane_q, lane_d;
   logic [ADDR_W:0]   words_left_q, words_left_d;
   logic [ADDR_W-1:0] raddr_q, raddr_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         shift_q      <= '0;
         lane_q       <= '0;
         words_left_q <= '0;
         raddr_q      <= '0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         lane_q       <= lane_d;
         words_left_q <= words_left_d;
         raddr_q      <= raddr_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      lane_d       = lane_q;
      words_left_d = words_left_q;
      raddr_d      = raddr_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               words_left_d = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
               raddr_d      = base_addr;
               state_d      = (num_words == '0) ? ST_FIN : ST_LOAD;
            end
         end
         ST_LOAD: begin
            shift_d      = ram_dout;
            lane_d       = '0;
            raddr_d      = raddr_q + 1'b1;
            words_left_d = words_left_q - 1'b1;
            state_d      = ST_STREAM;
         end
         ST_STREAM: begin
            if (coef_ready) begin
               if (lane_q != LAST_LANE) begin
                  shift_d = shift_q >> COEF_W;
                  lane_d  = lane_q + 1'b1;
               end else if (words_left_q != '0) begin
                  // Next word is already on ram_dout, so refill without a bubble.
                  shift_d      = ram_dout;
                  lane_d       = '0;
                  raddr_d      = raddr_q + 1'b1;
                  words_left_d = words_left_q - 1'b1;
               end else begin
                  state_d = ST_FIN;
               end
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Data is gated so nothing from a previous run leaks out while idle.
   assign coef_valid = (state_q == ST_STREAM);
   assign coef_data  = coef_valid ? shift_q[COEF_W-1:0] : '0;
   assign coef_last  = coef_valid && (lane_q == LAST_LANE) && (words_left_q == '0);
   assign busy       = (state_q != ST_IDLE);
   assign done       = (state_q == ST_FIN);
   assign ram_raddr  = raddr_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_ram_coef_unpacker.sv
// Self-checking bench for ram_coef_unpacker: RAM model, random back-pressure,
// queue scoreboard fed by a word/lane reference model.
module tb_ram_coef_unpacker;
  import kyber_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  num_words;
  logic [7:0]  ram_raddr;
  logic [95:0] ram_dout;
  logic        coef_valid;
  logic        coef_ready = 1'b0;
  logic [11:0] coef_data;
  logic        coef_last;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  logic [95:0] ram [256];
  logic [12:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int xfer_cnt = 0;
  int ready_mode = 0;
  int cyc = 0;

  ram_coef_unpacker dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_words(num_words), .ram_raddr(ram_raddr), .ram_dout(ram_dout),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
    .coef_last(coef_last), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  assign ram_dout = ram[ram_raddr];

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ready driver: 0 = always high, 1 = pattern 1,0,0,1, 2 = random
  always @(posedge clk) begin
    #1;
    cyc++;
    case (ready_mode)
      0:       coef_ready = 1'b1;
      1:       coef_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: coef_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // reference model: every word of the run, lanes low to high
  task automatic expect_run(input logic [7:0] b, input logic [8:0] n);
    int neff;
    logic [7:0] a;
    neff = (n > 9'd256) ? 256 : int'(n);
    for (int w = 0; w < neff; w++) begin
      a = b + 8'(w);
      for (int l = 0; l < 8; l++)
        exp_q.push_back({(w == neff - 1) && (l == 7), ram[a][12*l +: 12]});
    end
  endtask

  // monitor / scoreboard
  logic        prev_stall = 1'b0;
  logic        prev_xfer_nl = 1'b0;
  logic [11:0] prev_data;
  logic        prev_last;
  logic [7:0]  prev_raddr;
  logic [12:0] e;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall   = 1'b0;
      prev_xfer_nl = 1'b0;
    end else begin
      if (done) begin
        done_cnt++;
        chk("done_with_valid", 64'(coef_valid), 64'd0);
      end
      if (prev_stall) begin
        chk("stall_valid", 64'(coef_valid), 64'd1);
        chk("stall_data", 64'(coef_data), 64'(prev_data));
        chk("stall_last", 64'(coef_last), 64'(prev_last));
        chk("stall_raddr", 64'(ram_raddr), 64'(prev_raddr));
      end
      if (prev_xfer_nl) chk("no_bubble", 64'(coef_valid), 64'd1);
      if (coef_valid && coef_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_coef: got %0h required none", {coef_last, coef_data});
        end else begin
          e = exp_q.pop_front();
          chk("coef", 64'({coef_last, coef_data}), 64'(e));
        end
      end
      prev_stall   = coef_valid && !coef_ready;
      prev_xfer_nl = coef_valid && coef_ready && !coef_last;
      prev_data    = coef_data;
      prev_last    = coef_last;
      prev_raddr   = ram_raddr;
    end
  end

  // one run; noise drives start/base/num randomly while busy and at done
  task automatic run(input logic [7:0] b, input logic [8:0] n, input bit noise, input bit timed);
    int neff, t, d0;
    neff = (n > 9'd256) ? 256 : int'(n);
    @(posedge clk); #1;
    chk("idle_before_start", 64'(busy), 64'd0);
    d0 = done_cnt;
    base_addr = b;
    num_words = n;
    start = 1'b1;
    expect_run(b, n);
    @(posedge clk); #1;
    start = 1'b0;
    t = 1;
    if (neff == 0) begin
      chk("zero_done", 64'(done), 64'd1);
      chk("zero_valid", 64'(coef_valid), 64'd0);
    end else begin
      chk("load_raddr", 64'(ram_raddr), 64'(b));
      chk("load_valid", 64'(coef_valid), 64'd0);
      chk("load_busy", 64'(busy), 64'd1);
    end
    while (!done && t < 40 * neff + 50) begin
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        base_addr = 8'($urandom);
        num_words = 9'($urandom_range(0, 511));
      end
      @(posedge clk); #1;
      t++;
    end
    start = 1'b0;
    chk("done_seen", 64'(done), 64'd1);
    if (timed) chk("run_cycles", 64'(t), (neff == 0) ? 64'd1 : 64'(8 * neff + 2));
    if (noise) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("idle_after_done", 64'(busy), 64'd0);
    chk("done_one_cycle", 64'(done), 64'd0);
    @(posedge clk); #1;
    chk("done_count", 64'(done_cnt - d0), 64'd1);
    chk("exp_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(coef_valid), 64'd0);
    chk({tag, "_data"}, 64'(coef_data), 64'd0);
    chk({tag, "_last"}, 64'(coef_last), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_raddr"}, 64'(ram_raddr), 64'd0);
    chk({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
  endtask

  task automatic reset_mid_run();
    int t, x0, d0;
    @(posedge clk); #1;
    x0 = xfer_cnt;
    base_addr = 8'h40;
    num_words = 9'd2;
    start = 1'b1;
    expect_run(8'h40, 9'd2);
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
    while (xfer_cnt < x0 + 12 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("reached_word1_lane4", 64'(xfer_cnt - x0), 64'd12);
    #1 rst = 1'b1;
    #1 check_reset_outputs("abort");
    d0 = done_cnt;
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("no_done_after_abort", 64'(done_cnt - d0), 64'd0);
    run(8'h41, 9'd1, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    num_words = '0;
    for (int i = 0; i < 256; i++) ram[i] = {$urandom, $urandom, $urandom};
    for (int l = 0; l < 8; l++) ram[8'h10][12*l +: 12] = 12'(l + 1);
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    ready_mode = 0;
    run(8'h10, 9'd1, 1'b0, 1'b1);
    ready_mode = 1;
    run(8'h20, 9'd2, 1'b0, 1'b0);
    run(8'hFE, 9'd3, 1'b0, 1'b0);
    ready_mode = 0;
    run(8'hFF, 9'd2, 1'b0, 1'b1);
    run(8'h00, 9'd0, 1'b0, 1'b1);
    run(8'h37, 9'd256, 1'b0, 1'b1);
    run(8'h80, 9'd300, 1'b0, 1'b1);
    ready_mode = 2;
    for (int k = 0; k < 6; k++)
      run(8'($urandom), 9'($urandom_range(1, 6)), 1'b1, 1'b0);
    ready_mode = 0;
    reset_mid_run();
    ready_mode = 2;
    run(8'hF0, 9'd3, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
